// File: rtl/axi_lite_ram_pkg.sv
// Shared types for the AXI4-Lite RAM responder: response codes and the
// read/write channel state encodings.
package axi_lite_ram_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_A,
        W_HAVE_D,
        W_RESP
    } wstate_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_e;

endpackage

// File: rtl/axi_lite_ram_if.sv
// AXI4-Lite bus bundle between a manager and the RAM responder.
interface axi_lite_ram_if;
    import axi_lite_ram_pkg::*;

    logic        awvalid;
    logic        awready;
    logic [31:0] awaddress;
    logic [2:0]  awprot;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    resp_t       bresp;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddress;
    logic [2:0]  arprot;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    resp_t       rresp;

    modport master (
        output awvalid, awaddress, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddress, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddress, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddress, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/axi_lite_ram_array.sv
// Word-wide storage with a byte-enabled write port and a registered read port.
// Reads sample the array before a same-edge write lands (read-before-write).
module axi_lite_ram_array #(
    parameter  int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [31:0]      wdata_i,
    input  logic [3:0]       wbe_i,
    input  logic             re_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // NOTE: storage has no reset so it maps onto RAM macros; contents survive reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wbe_i[b]) begin
                    mem[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_lite_ram.sv
// AXI4-Lite responder backed by a word-addressed RAM; independent read and
// write channels with one outstanding transaction each.
module axi_lite_ram
    import axi_lite_ram_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input logic           clk,
    input logic           reset,
    axi_lite_ram_if.slave bus
);

    localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS);
    localparam logic [63:0] DEPTH_BYTES = 64'(DEPTH_WORDS) << 2;

    wstate_e     w_state_q;
    logic        awready_q;
    logic        wready_q;
    logic        bvalid_q;
    resp_t       bresp_q;
    logic [31:0] awaddr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    rstate_e     r_state_q;
    logic        arready_q;
    logic        rvalid_q;
    resp_t       rresp_q;

    logic aw_hs, w_hs, ar_hs;
    assign aw_hs = bus.awvalid & awready_q;
    assign w_hs  = bus.wvalid  & wready_q;
    assign ar_hs = bus.arvalid & arready_q;

    // A half already captured comes from its latch; the other half is live on the bus.
    logic [31:0] w_addr_eff, w_data_eff;
    logic [3:0]  w_strb_eff;
    assign w_addr_eff = (w_state_q == W_HAVE_A) ? awaddr_q : bus.awaddress;
    assign w_data_eff = (w_state_q == W_HAVE_D) ? wdata_q  : bus.wdata;
    assign w_strb_eff = (w_state_q == W_HAVE_D) ? wstrb_q  : bus.wstrb;

    logic w_commit;
    assign w_commit = ((w_state_q == W_IDLE)   & aw_hs & w_hs)
                    | ((w_state_q == W_HAVE_A) & w_hs)
                    | ((w_state_q == W_HAVE_D) & aw_hs);

    // Addresses below BASE_ADDR wrap to large offsets and fall out of range.
    logic [31:0] w_off, r_off;
    logic        w_in_range, r_in_range;
    assign w_off      = w_addr_eff - BASE_ADDR;
    assign r_off      = bus.araddress - BASE_ADDR;
    assign w_in_range = {32'd0, w_off} < DEPTH_BYTES;
    assign r_in_range = {32'd0, r_off} < DEPTH_BYTES;

    resp_t w_resp_d, r_resp_d;
    assign w_resp_d = w_in_range ? RESP_OKAY : RESP_SLVERR;
    assign r_resp_d = r_in_range ? RESP_OKAY : RESP_SLVERR;

    logic unused_bits;
    assign unused_bits = ^{w_off[1:0], r_off[1:0], bus.awprot, bus.arprot};

    logic [31:0] mem_rdata;

    axi_lite_ram_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .we_i    (w_commit & w_in_range),
        .waddr_i (w_off[IDX_W+1:2]),
        .wdata_i (w_data_eff),
        .wbe_i   (w_strb_eff),
        .re_i    (ar_hs & r_in_range),
        .raddr_i (r_off[IDX_W+1:2]),
        .rdata_o (mem_rdata)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (aw_hs && w_hs) begin
                        w_state_q <= W_RESP;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= w_resp_d;
                    end else if (aw_hs) begin
                        w_state_q <= W_HAVE_A;
                        awready_q <= 1'b0;
                        awaddr_q  <= bus.awaddress;
                    end else if (w_hs) begin
                        w_state_q <= W_HAVE_D;
                        wready_q  <= 1'b0;
                        wdata_q   <= bus.wdata;
                        wstrb_q   <= bus.wstrb;
                    end
                end
                W_HAVE_A: begin
                    if (w_hs) begin
                        w_state_q <= W_RESP;
                        wready_q  <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= w_resp_d;
                    end
                end
                W_HAVE_D: begin
                    if (aw_hs) begin
                        w_state_q <= W_RESP;
                        awready_q <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= w_resp_d;
                    end
                end
                W_RESP: begin
                    if (bus.bready) begin
                        w_state_q <= W_IDLE;
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                default: begin
                    w_state_q <= W_IDLE;
                    awready_q <= 1'b1;
                    wready_q  <= 1'b1;
                    bvalid_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_state_q <= R_DATA;
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rresp_q   <= r_resp_d;
                    end
                end
                R_DATA: begin
                    if (bus.rready) begin
                        r_state_q <= R_IDLE;
                        arready_q <= 1'b1;
                        rvalid_q  <= 1'b0;
                    end
                end
                default: begin
                    r_state_q <= R_IDLE;
                    arready_q <= 1'b1;
                    rvalid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.awready = awready_q;
    assign bus.wready  = wready_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;
    assign bus.arready = arready_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rresp   = rresp_q;
    // The array's read register is not reset; it is only visible during a good response.
    assign bus.rdata   = (rvalid_q && rresp_q == RESP_OKAY) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_axi_lite_ram.sv
// Directed bench for axi_lite_ram: handshake ordering, byte strobes, decode
// errors, read-before-write and asynchronous reset mid-transaction.
module tb_axi_lite_ram;
    import axi_lite_ram_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    axi_lite_ram_if bus();

    axi_lite_ram #(
        .DEPTH_WORDS(1024),
        .BASE_ADDR  (32'h0000_0000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are observed there too.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output resp_t resp, output bit ok);
        bit aw_done, w_done, aw_f, w_f;
        int n;
        ok = 1'b0;
        resp = 2'b11;
        aw_done = 1'b0;
        w_done = 1'b0;
        bus.awaddress = addr;
        bus.wdata = data;
        bus.wstrb = strb;
        bus.awvalid = 1'b1;
        bus.wvalid = 1'b1;
        n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            aw_f = bus.awvalid && bus.awready;
            w_f  = bus.wvalid && bus.wready;
            @(negedge clk);
            if (aw_f) begin aw_done = 1'b1; bus.awvalid = 1'b0; end
            if (w_f) begin w_done = 1'b1; bus.wvalid = 1'b0; end
            n++;
        end
        if (!(aw_done && w_done)) begin
            bus.awvalid = 1'b0;
            bus.wvalid = 1'b0;
            return;
        end
        bus.bready = 1'b1;
        n = 0;
        while (!bus.bvalid && n < 20) begin @(negedge clk); n++; end
        if (bus.bvalid) begin resp = bus.bresp; ok = 1'b1; end
        @(negedge clk);
        bus.bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                           output resp_t resp, output int lat, output bit ok);
        bit fired, f;
        int n;
        ok = 1'b0;
        data = 32'hxxxx_xxxx;
        resp = 2'b11;
        lat = 0;
        fired = 1'b0;
        bus.araddress = addr;
        bus.arvalid = 1'b1;
        n = 0;
        while (!fired && n < 20) begin
            f = bus.arready;
            @(negedge clk);
            if (f) begin fired = 1'b1; bus.arvalid = 1'b0; end
            n++;
        end
        if (!fired) begin bus.arvalid = 1'b0; return; end
        bus.rready = 1'b1;
        lat = 1;
        n = 0;
        while (!bus.rvalid && n < 20) begin @(negedge clk); lat++; n++; end
        if (bus.rvalid) begin data = bus.rdata; resp = bus.rresp; ok = 1'b1; end
        @(negedge clk);
        bus.rready = 1'b0;
    endtask

    task automatic test_reset();
        vectors++; if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin miscompares++; $display("FAIL reset_ready: got %b want 111", {bus.awready, bus.wready, bus.arready}); end
        vectors++; if ({bus.bvalid, bus.rvalid} !== 2'b00) begin miscompares++; $display("FAIL reset_valid: got %b want 00", {bus.bvalid, bus.rvalid}); end
        vectors++; if ({bus.bresp, bus.rresp} !== 4'b0000) begin miscompares++; $display("FAIL reset_resp: got %b want 0000", {bus.bresp, bus.rresp}); end
        vectors++; if (bus.rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
    endtask

    task automatic test_same_cycle_write();
        logic [31:0] d; resp_t r; int lat; bit ok;
        bus.awaddress = 32'h10; bus.wdata = 32'hDEAD_BEEF; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        vectors++; if (bus.bvalid !== 1'b1) begin miscompares++; $display("FAIL t1_bvalid_latency: got %b want 1", bus.bvalid); end
        vectors++; if ({bus.awready, bus.wready} !== 2'b00) begin miscompares++; $display("FAIL t1_ready_in_resp: got %b want 00", {bus.awready, bus.wready}); end
        vectors++; if (bus.bresp !== RESP_OKAY) begin miscompares++; $display("FAIL t1_bresp: got %b want 00", bus.bresp); end
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        vectors++; if ({bus.bvalid, bus.awready, bus.wready} !== 3'b011) begin miscompares++; $display("FAIL t1_after_b: got %b want 011", {bus.bvalid, bus.awready, bus.wready}); end
        do_read(32'h10, d, r, lat, ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL t1_read_timeout: got %b want 1", ok); end
        vectors++; if (d !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL t1_rdata: got %h want deadbeef", d); end
        vectors++; if (r !== RESP_OKAY) begin miscompares++; $display("FAIL t1_rresp: got %b want 00", r); end
        vectors++; if (lat !== 1) begin miscompares++; $display("FAIL t1_rvalid_latency: got %0d want 1", lat); end
        // addr[1:0] ignored: an unaligned address hits the same word
        do_read(32'h13, d, r, lat, ok);
        vectors++; if (d !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL t1_unaligned_rdata: got %h want deadbeef", d); end
    endtask

    task automatic test_w_before_aw();
        logic [31:0] d; resp_t r; int lat; bit ok;
        bus.wdata = 32'h1122_3344; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(negedge clk);
        bus.wvalid = 1'b0;
        vectors++; if ({bus.awready, bus.wready, bus.bvalid} !== 3'b100) begin miscompares++; $display("FAIL t2_have_d: got %b want 100", {bus.awready, bus.wready, bus.bvalid}); end
        @(negedge clk);
        vectors++; if (bus.bvalid !== 1'b0) begin miscompares++; $display("FAIL t2_no_early_b: got %b want 0", bus.bvalid); end
        bus.awaddress = 32'h20; bus.awvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++; if ({bus.bvalid, bus.bresp, bus.awready} !== 4'b1000) begin miscompares++; $display("FAIL t2_hold_%0d: got bvalid/bresp/awready %b want 1000", i, {bus.bvalid, bus.bresp, bus.awready}); end
            @(negedge clk);
        end
        vectors++; if (bus.bvalid !== 1'b1) begin miscompares++; $display("FAIL t2_hold_final: got %b want 1", bus.bvalid); end
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        vectors++; if ({bus.bvalid, bus.awready} !== 2'b01) begin miscompares++; $display("FAIL t2_release: got %b want 01", {bus.bvalid, bus.awready}); end
        do_read(32'h20, d, r, lat, ok);
        vectors++; if (d !== 32'h1122_3344) begin miscompares++; $display("FAIL t2_rdata: got %h want 11223344", d); end
    endtask

    task automatic test_strobes();
        logic [31:0] d; resp_t r; int lat; bit ok;
        do_write(32'h30, 32'hFFFF_FFFF, 4'hF, r, ok);
        vectors++; if (ok !== 1'b1 || r !== RESP_OKAY) begin miscompares++; $display("FAIL t3_full_write: got ok=%b resp=%b want 1/00", ok, r); end
        do_write(32'h30, 32'h00AA_00BB, 4'b0101, r, ok);
        do_read(32'h30, d, r, lat, ok);
        vectors++; if (d !== 32'hFFAA_FFBB) begin miscompares++; $display("FAIL t3_strobe_rdata: got %h want ffaaffbb", d); end
        do_write(32'h30, 32'h1234_5678, 4'b0000, r, ok);
        vectors++; if (ok !== 1'b1 || r !== RESP_OKAY) begin miscompares++; $display("FAIL t3_zero_strb_bresp: got ok=%b resp=%b want 1/00", ok, r); end
        do_read(32'h30, d, r, lat, ok);
        vectors++; if (d !== 32'hFFAA_FFBB) begin miscompares++; $display("FAIL t3_zero_strb_rdata: got %h want ffaaffbb", d); end
    endtask

    task automatic test_decode();
        logic [31:0] d; resp_t r; int lat; bit ok;
        do_write(32'h0, 32'hA5A5_0000, 4'hF, r, ok);
        do_write(32'h1000, 32'h1234_5678, 4'hF, r, ok);
        vectors++; if (ok !== 1'b1 || r !== RESP_SLVERR) begin miscompares++; $display("FAIL t4_oor_bresp: got ok=%b resp=%b want 1/10", ok, r); end
        do_read(32'h1000, d, r, lat, ok);
        vectors++; if (r !== RESP_SLVERR) begin miscompares++; $display("FAIL t4_oor_rresp: got %b want 10", r); end
        vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL t4_oor_rdata: got %h want 0", d); end
        do_read(32'h0, d, r, lat, ok);
        vectors++; if (d !== 32'hA5A5_0000) begin miscompares++; $display("FAIL t4_word0_kept: got %h want a5a50000", d); end
        do_write(32'hFFC, 32'hCAFE_F00D, 4'hF, r, ok);
        vectors++; if (r !== RESP_OKAY) begin miscompares++; $display("FAIL t4_last_bresp: got %b want 00", r); end
        do_read(32'hFFC, d, r, lat, ok);
        vectors++; if (d !== 32'hCAFE_F00D || r !== RESP_OKAY) begin miscompares++; $display("FAIL t4_last_rdata: got %h/%b want cafef00d/00", d, r); end
    endtask

    task automatic test_read_before_write();
        logic [31:0] d; resp_t r; int lat; bit ok;
        do_write(32'h40, 32'h7, 4'hF, r, ok);
        bus.awaddress = 32'h40; bus.wdata = 32'h5; bus.wstrb = 4'hF;
        bus.araddress = 32'h40;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        vectors++; if ({bus.rvalid, bus.bvalid, bus.arready} !== 3'b110) begin miscompares++; $display("FAIL t5_valids: got %b want 110", {bus.rvalid, bus.bvalid, bus.arready}); end
        vectors++; if (bus.rdata !== 32'h7) begin miscompares++; $display("FAIL t5_old_data: got %h want 7", bus.rdata); end
        bus.bready = 1'b1; bus.rready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0; bus.rready = 1'b0;
        do_read(32'h40, d, r, lat, ok);
        vectors++; if (d !== 32'h5) begin miscompares++; $display("FAIL t5_new_data: got %h want 5", d); end
    endtask

    task automatic test_reset_mid_transaction();
        logic [31:0] d; resp_t r; int lat; bit ok;
        do_write(32'h50, 32'h0BAD_F00D, 4'hF, r, ok);
        bus.awaddress = 32'h50; bus.awvalid = 1'b1;
        bus.araddress = 32'h50; bus.arvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0; bus.arvalid = 1'b0;
        vectors++; if ({bus.awready, bus.wready, bus.arready, bus.rvalid} !== 4'b0101) begin miscompares++; $display("FAIL t6_pre_state: got %b want 0101", {bus.awready, bus.wready, bus.arready, bus.rvalid}); end
        #2 reset = 1'b0;
        #1;
        vectors++; if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin miscompares++; $display("FAIL t6_async_ready: got %b want 111", {bus.awready, bus.wready, bus.arready}); end
        vectors++; if ({bus.bvalid, bus.rvalid} !== 2'b00 || bus.rdata !== 32'h0) begin miscompares++; $display("FAIL t6_async_valid: got %b rdata %h want 00/0", {bus.bvalid, bus.rvalid}, bus.rdata); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        // The AW taken before reset must be gone: W alone cannot complete
        bus.wdata = 32'hFFFF_FFFF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(negedge clk);
        bus.wvalid = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (bus.bvalid !== 1'b0) begin miscompares++; $display("FAIL t6_aw_discarded: got %b want 0", bus.bvalid); end
        bus.awaddress = 32'h54; bus.awvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0;
        vectors++; if (bus.bvalid !== 1'b1) begin miscompares++; $display("FAIL t6_completion: got %b want 1", bus.bvalid); end
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        do_read(32'h50, d, r, lat, ok);
        vectors++; if (d !== 32'h0BAD_F00D) begin miscompares++; $display("FAIL t6_target_kept: got %h want 0badf00d", d); end
        do_read(32'h54, d, r, lat, ok);
        vectors++; if (d !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL t6_post_write: got %h want ffffffff", d); end
    endtask

    initial begin
        reset = 1'b0;
        bus.awvalid = 1'b0; bus.awaddress = '0; bus.awprot = '0;
        bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
        bus.bready = 1'b0;
        bus.arvalid = 1'b0; bus.araddress = '0; bus.arprot = '0;
        bus.rready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b1;
        @(negedge clk);
        test_same_cycle_write();
        test_w_before_aw();
        test_strobes();
        test_decode();
        test_read_before_write();
        test_reset_mid_transaction();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
